// File: rtl/z_core_alu_pkg.sv
// Shared ALU definitions: opcode map, widths, BIST state encodings and ROM row layout.
package z_core_alu_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [OP_W-1:0] ALU_OR   = 4'd8;
    localparam logic [OP_W-1:0] ALU_AND  = 4'd9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
        logic [DATA_W-1:0] exp_out;
        logic              exp_br;
        logic              chk_br;
    } rom_row_t;

    // Rows in this revision never check the branch flag.
    function automatic rom_row_t mk_row(input logic [OP_W-1:0] op,
                                        input logic [DATA_W-1:0] in1,
                                        input logic [DATA_W-1:0] in2,
                                        input logic [DATA_W-1:0] exp_out);
        rom_row_t r;
        r.op      = op;
        r.in1     = in1;
        r.in2     = in2;
        r.exp_out = exp_out;
        r.exp_br  = 1'b0;
        r.chk_br  = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/z_core_alu_bist_rom.sv
// Combinational BIST vector table: index -> {op, in1, in2, exp_out, exp_br, chk_br}.
module z_core_alu_bist_rom
    import z_core_alu_pkg::*;
(
    input  logic [3:0] idx,
    output rom_row_t   row
);

    always_comb begin
        row = '0;
        case (idx)
            4'd0:  row = mk_row(ALU_ADD,  32'd2,          32'd3,  32'd5);
            4'd1:  row = mk_row(ALU_SUB,  32'd5,          32'd3,  32'd2);
            4'd2:  row = mk_row(ALU_SLL,  32'd2,          32'd1,  32'd4);
            4'd3:  row = mk_row(ALU_SLL,  32'd2,          32'd8,  32'd512);
            4'd4:  row = mk_row(ALU_SLT,  32'd10,         32'd20, 32'd1);
            4'd5:  row = mk_row(ALU_SLTU, 32'd20,         32'd10, 32'd0);
            4'd6:  row = mk_row(ALU_XOR,  32'd12,         32'd5,  32'd9);
            4'd7:  row = mk_row(ALU_SRL,  32'd12,         32'd2,  32'd3);
            4'd8:  row = mk_row(ALU_ADD,  32'hFFFF_FFFF,  32'd1,  32'd0);
            4'd9:  row = mk_row(ALU_SUB,  32'd0,          32'd1,  32'hFFFF_FFFF);
            4'd10: row = mk_row(ALU_SLT,  32'hFFFF_FFFF,  32'd1,  32'd1);
            4'd11: row = mk_row(ALU_SLTU, 32'hFFFF_FFFF,  32'd1,  32'd0);
            4'd12: row = mk_row(ALU_SRA,  32'h8000_0000,  32'd4,  32'hF800_0000);
            4'd13: row = mk_row(ALU_SLL,  32'd1,          32'd33, 32'd2);
            4'd14: row = mk_row(ALU_OR,   32'h0000_00F0,  32'h0F, 32'hFF);
            4'd15: row = mk_row(ALU_AND,  32'h0000_00F0,  32'h3C, 32'h30);
        endcase
    end

endmodule

// File: rtl/z_core_alu_bist.sv
// BIST sequencer for z_core_alu: drives ROM vectors, checks results, reports pass/fail.
module z_core_alu_bist
    import z_core_alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned STOP_ON_FAIL  = 0,
    parameter int unsigned NUM_VECTORS   = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [OP_W-1:0]   alu_inst_type,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_branch,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        fail_count,
    output logic [3:0]        first_fail_idx
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_IDX    = 4'(NUM_VECTORS - 1);

    logic [1:0]        state;
    logic [3:0]        idx;
    logic [3:0]        settle;
    logic [3:0]        rom_idx;
    rom_row_t          rom_row;
    logic [DATA_W-1:0] exp_out;
    logic              exp_br;
    logic              chk_br;
    logic              mismatch;

    // The ROM is addressed with the row about to be loaded, so the registered
    // expectations below stay aligned with the operands held on the ALU.
    assign rom_idx = (state == ST_CHECK) ? idx + 4'd1 : '0;

    z_core_alu_bist_rom u_rom (
        .idx (rom_idx),
        .row (rom_row)
    );

    assign mismatch = (alu_out != exp_out) | (chk_br & (alu_branch != exp_br));
    assign busy     = (state == ST_DRIVE) | (state == ST_CHECK);
    assign pass     = done & (fail_count == 8'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= ST_IDLE;
            idx            <= '0;
            settle         <= '0;
            alu_in1        <= '0;
            alu_in2        <= '0;
            alu_inst_type  <= '0;
            exp_out        <= '0;
            exp_br         <= 1'b0;
            chk_br         <= 1'b0;
            done           <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx            <= '0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        done           <= 1'b0;
                        alu_in1        <= rom_row.in1;
                        alu_in2        <= rom_row.in2;
                        alu_inst_type  <= rom_row.op;
                        exp_out        <= rom_row.exp_out;
                        exp_br         <= rom_row.exp_br;
                        chk_br         <= rom_row.chk_br;
                        settle         <= SETTLE_INIT;
                        state          <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (settle == 4'd0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle <= settle - 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (fail_count == 8'd0) begin
                            first_fail_idx <= idx;
                        end
                        if (fail_count != 8'hFF) begin
                            fail_count <= fail_count + 8'd1;
                        end
                    end
                    if ((idx == LAST_IDX) || ((STOP_ON_FAIL != 0) && mismatch)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx           <= idx + 4'd1;
                        alu_in1       <= rom_row.in1;
                        alu_in2       <= rom_row.in2;
                        alu_inst_type <= rom_row.op;
                        exp_out       <= rom_row.exp_out;
                        exp_br        <= rom_row.exp_br;
                        chk_br        <= rom_row.chk_br;
                        settle        <= SETTLE_INIT;
                        state         <= ST_DRIVE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z_core_alu_bist.sv
// Directed bench: three sequencer instances (default, stop-on-fail, long settle) beside a reference ALU.
module tb_z_core_alu_bist;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return {31'b0, $signed(a) < $signed(b)};
            4'd4: return {31'b0, a < b};
            4'd5: return a ^ b;
            4'd6: return a >> b[4:0];
            4'd7: return $unsigned($signed(a) >>> b[4:0]);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // Instance a: defaults
    logic        start_a = 1'b0, fault_a = 1'b0;
    logic [31:0] in1_a, in2_a, out_a;
    logic [3:0]  op_a, ffi_a;
    logic        busy_a, done_a, pass_a;
    logic [7:0]  fc_a;
    assign out_a = (fault_a && op_a == 4'd5) ? 32'd0 : alu_ref(op_a, in1_a, in2_a);

    z_core_alu_bist u_a (
        .clk(clk), .rstn(rstn), .start(start_a),
        .alu_in1(in1_a), .alu_in2(in2_a), .alu_inst_type(op_a),
        .alu_out(out_a), .alu_branch(1'b0),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_count(fc_a), .first_fail_idx(ffi_a)
    );

    // Instance b: stop on first failure, always faulted on XOR
    logic        start_b = 1'b0;
    logic [31:0] in1_b, in2_b, out_b;
    logic [3:0]  op_b, ffi_b;
    logic        busy_b, done_b, pass_b;
    logic [7:0]  fc_b;
    assign out_b = (op_b == 4'd5) ? 32'd0 : alu_ref(op_b, in1_b, in2_b);

    z_core_alu_bist #(.STOP_ON_FAIL(1)) u_b (
        .clk(clk), .rstn(rstn), .start(start_b),
        .alu_in1(in1_b), .alu_in2(in2_b), .alu_inst_type(op_b),
        .alu_out(out_b), .alu_branch(1'b0),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_count(fc_b), .first_fail_idx(ffi_b)
    );

    // Instance c: three settle cycles, golden ALU
    logic        start_c = 1'b0;
    logic [31:0] in1_c, in2_c, out_c;
    logic [3:0]  op_c, ffi_c;
    logic        busy_c, done_c, pass_c;
    logic [7:0]  fc_c;
    assign out_c = alu_ref(op_c, in1_c, in2_c);

    z_core_alu_bist #(.SETTLE_CYCLES(3)) u_c (
        .clk(clk), .rstn(rstn), .start(start_c),
        .alu_in1(in1_c), .alu_in2(in2_c), .alu_inst_type(op_c),
        .alu_out(out_c), .alu_branch(1'b0),
        .busy(busy_c), .done(done_c), .pass(pass_c),
        .fail_count(fc_c), .first_fail_idx(ffi_c)
    );

    logic [3:0] exp_ops [16] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                 4'd0, 4'd1, 4'd3, 4'd4, 4'd7, 4'd2, 4'd8, 4'd9};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(output int unsigned cycles);
        cycles = 0;
        while (!done_a && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    int unsigned cyc;
    logic [31:0] cap1, cap2;

    initial begin
        // Reset state
        #3;
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        check("rst_done", {31'b0, done_a}, 32'd0);
        check("rst_pass", {31'b0, pass_a}, 32'd0);
        check("rst_fc",   {24'b0, fc_a},   32'd0);
        check("rst_in1",  in1_a,           32'd0);
        check("rst_in2",  in2_a,           32'd0);
        check("rst_op",   {28'b0, op_a},   32'd0);
        tick();
        rstn = 1'b1;
        tick();

        // Golden run, defaults
        pulse_a();
        check("gold_busy", {31'b0, busy_a}, 32'd1);
        check("gold_op0",  {28'b0, op_a},   32'd0);
        check("gold_in1",  in1_a,           32'd2);
        check("gold_in2",  in2_a,           32'd3);
        wait_done_a(cyc);
        check("gold_lat",  cyc,             32'd32);
        check("gold_pass", {31'b0, pass_a}, 32'd1);
        check("gold_fc",   {24'b0, fc_a},   32'd0);
        check("gold_busy_end", {31'b0, busy_a}, 32'd0);

        // Faulted XOR, with ignored start pulses mid-run
        fault_a = 1'b1;
        pulse_a();
        cyc = 0;
        while (!done_a && cyc < 200) begin
            start_a = (cyc == 5 || cyc == 10);
            tick();
            cyc++;
        end
        start_a = 1'b0;
        check("flt_lat",  cyc,              32'd32);
        check("flt_pass", {31'b0, pass_a},  32'd0);
        check("flt_fc",   {24'b0, fc_a},    32'd1);
        check("flt_ffi",  {28'b0, ffi_a},   32'd6);
        tick();
        check("flt_hold_done", {31'b0, done_a}, 32'd1);

        // Restart from DONE clears results
        fault_a = 1'b0;
        pulse_a();
        check("rs_done", {31'b0, done_a}, 32'd0);
        check("rs_fc",   {24'b0, fc_a},   32'd0);
        check("rs_ffi",  {28'b0, ffi_a},  32'd0);
        check("rs_busy", {31'b0, busy_a}, 32'd1);
        wait_done_a(cyc);
        check("rs_lat",  cyc,             32'd32);
        check("rs_pass", {31'b0, pass_a}, 32'd1);

        // Stop on fail
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 200) begin
            tick();
            cyc++;
        end
        check("sof_lat",  cyc,              32'd14);
        check("sof_pass", {31'b0, pass_b},  32'd0);
        check("sof_fc",   {24'b0, fc_b},    32'd1);
        check("sof_ffi",  {28'b0, ffi_b},   32'd6);

        // Long settle: operands hold for each 4-cycle window
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        cyc = 0;
        cap1 = in1_c;
        cap2 = in2_c;
        check("set_op", {28'b0, op_c}, {28'b0, exp_ops[0]});
        while (!done_c && cyc < 300) begin
            tick();
            cyc++;
            if (cyc < 64) begin
                if (cyc % 4 == 0) begin
                    cap1 = in1_c;
                    cap2 = in2_c;
                    check("set_op", {28'b0, op_c}, {28'b0, exp_ops[cyc / 4]});
                    if (cyc == 48) check("set_sra_in1", in1_c, 32'h8000_0000);
                end else begin
                    check("set_hold_in1", in1_c, cap1);
                    check("set_hold_in2", in2_c, cap2);
                end
            end
        end
        check("set_lat",  cyc,             32'd64);
        check("set_pass", {31'b0, pass_c}, 32'd1);

        // Reset mid-run
        pulse_a();
        repeat (9) tick();
        rstn = 1'b0;
        #1;
        check("mrst_busy", {31'b0, busy_a}, 32'd0);
        check("mrst_done", {31'b0, done_a}, 32'd0);
        check("mrst_fc",   {24'b0, fc_a},   32'd0);
        check("mrst_in1",  in1_a,           32'd0);
        check("mrst_in2",  in2_a,           32'd0);
        check("mrst_op",   {28'b0, op_a},   32'd0);
        tick();
        rstn = 1'b1;
        tick();
        check("mrst_idle", {31'b0, busy_a}, 32'd0);
        pulse_a();
        wait_done_a(cyc);
        check("mrst_lat",  cyc,             32'd32);
        check("mrst_pass", {31'b0, pass_a}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
